rv523_step_ctrl: RTL and testbench
==================================

// Module: rv523_step_ctrl
// PURPOSE
// - Run/step/halt controller for the discrete-cell RV523 CPU board: debounces front-panel buttons, produces cpu_ce clock-enable.
// - Sits upstream of all cell-level datapath logic; every CPU register gates its update on cpu_ce.
// - Provides single-step, free-run, slow-run (visible on DECAP_LED indicators) and halt-on-ebreak.
// PARAMETERS
// - DEBOUNCE_CYCLES  16'd50000  stable-level cycles before a button change is accepted
// - SLOW_DIV         24         slow-run tick every 2**SLOW_DIV cycles
// - PC_W             32         width of cpu_pc / bp_addr
// PORTS
// - clk        in   1     board clock, all logic rising-edge
// - rst        in   1     synchronous, active-high reset
// - btn_run    in   1     raw run button, active-high, asynchronous to clk
// - btn_step   in   1     raw step button, active-high, asynchronous
// - btn_halt   in   1     raw halt button, active-high, asynchronous
// - sw_slow    in   1     level switch: 1 = slow-run in RUN state (2-FF synchronised)
// - halt_req   in   1     CPU ebreak/fault request, synchronous to clk
// - cpu_pc     in   PC_W  current PC (breakpoint compare only)
// - bp_addr    in   PC_W  breakpoint address (breakpoint compare only)
// - bp_valid   in   1     breakpoint armed (breakpoint compare only)
// - cpu_ce     out  1     CPU clock enable
// - running    out  1     1 while state==RUN
// - step_done  out  1     one-cycle pulse after a step's enable cycle
// - halted_by  out  2     00 none/button, 01 halt_req, 10 breakpoint; holds until next run/step
// BEHAVIOUR
// - Reset (rst=1 at edge): state=HALT, cpu_ce=0, running=0, step_done=0, halted_by=00,
//   debouncers=released, counters=0. Reset mid-step/mid-run aborts immediately, no further cpu_ce.
// - Debounce per button: 2-FF sync, counter counts while sync level != accepted level, clears otherwise;
//   at DEBOUNCE_CYCLES-1 accepted level updates. Press = accepted 0->1 edge, one-cycle pulse.
// - Latency: raw edge -> press pulse = 2 + DEBOUNCE_CYCLES cycles.
// - States: HALT, RUN, STEP.
//   HALT: halt_press ignored; step_press -> STEP; run_press -> RUN; halted_by cleared on leaving.
//   STEP: cpu_ce=1 for exactly this one cycle; next state HALT; step_done=1 in following cycle.
//   RUN: cpu_ce = tick & ~halt_req; tick=1 every cycle if sw_slow=0, else when slow counter wraps.
//     halt_press -> HALT (halted_by=00); halt_req -> HALT (halted_by=01), cpu_ce forced 0 that cycle.
//     step_press/run_press ignored in RUN.
// - Simultaneous presses in HALT: step has priority over run. In RUN: halt_req > breakpoint > halt_press.
// - Slow counter: SLOW_DIV bits, free-running only in RUN with sw_slow=1, reset to 0 on entering RUN
//   and on sw_slow 0->1; tick when counter == all ones (wraps to 0).
// - sw_slow change while RUN takes effect after its 2-FF sync; no glitch pulse on cpu_ce.
// - cpu_ce is registered-state combinational gating only; never asserted in HALT.
// CONFIGURATION
// - RV523_BREAKPOINT_EN defined: in RUN, if bp_valid && cpu_pc==bp_addr && tick, cpu_ce=0 that
//   cycle, next state HALT, halted_by=10. Step from HALT executes regardless of match (step-off).
// - Undefined: cpu_pc/bp_addr/bp_valid unused (ports kept), halted_by never 10.
// STRUCTURE
// - Package rv523_ctrl_pkg: typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} step_state_t;
//   halt-cause localparams HC_NONE=2'b00, HC_REQ=2'b01, HC_BP=2'b10.
// - Sub-module rv523_debounce (sync + counter + edge pulse), instantiated three times.
// TESTING (bench DEBOUNCE_CYCLES=4, SLOW_DIV=3)
// - Reset: rst=1 2 cycles with buttons high -> cpu_ce=0, running=0, halted_by=00, no press after release of rst.
// - Bounce: btn_step toggled every 2 cycles for 10 cycles then held 1 -> exactly one cpu_ce pulse, one step_done.
// - Run/halt: run press, count 20 cycles -> cpu_ce high 20 cycles; halt_req=1 -> cpu_ce=0 same cycle, halted_by=01.
// - Slow: RUN with sw_slow=1 for 32 cycles -> cpu_ce pulses exactly 4 times, period 8.
// - Priority: step and run accepted same cycle in HALT -> STEP taken, one cpu_ce, back to HALT.
// - RV523_BREAKPOINT_EN: bp_addr=32'h0000_0010, cpu_pc ramps 0,4,8,... -> halt at pc 0x10, halted_by=10; step -> one cpu_ce.

Source files
------------

// File: rtl/rv523_ctrl_pkg.sv
// Shared types for the RV523 run/step/halt controller: FSM state encoding and halt-cause codes.
package rv523_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } step_state_t;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_REQ  = 2'b01;
  localparam logic [1:0] HC_BP   = 2'b10;

endpackage

// File: rtl/rv523_step_ctrl_debounce.sv
// rv523_debounce: 2-FF synchroniser, stable-level counter and one-cycle press pulse for one button.
module rv523_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic        sync1_r;
  logic        sync2_r;
  logic        level_r;
  logic        press_r;
  logic [15:0] cnt_r;

  // Synchronise, accept a new level once it has been stable long enough, pulse on accepted rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == DEBOUNCE_CYCLES - 16'd1) begin
          level_r <= sync2_r;
          press_r <= sync2_r;
          cnt_r   <= 16'd0;
        end else begin
          cnt_r <= cnt_r + 16'd1;
        end
      end else begin
        cnt_r <= 16'd0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/rv523_step_ctrl.sv
// rv523_step_ctrl: run/step/halt controller producing the RV523 cpu_ce clock enable.
// Define RV523_BREAKPOINT_EN to halt RUN when cpu_pc matches an armed bp_addr.
module rv523_step_ctrl
  import rv523_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          SLOW_DIV        = 24,
  parameter int          PC_W            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_run,
  input  logic            btn_step,
  input  logic            btn_halt,
  input  logic            sw_slow,
  input  logic            halt_req,
  input  logic [PC_W-1:0] cpu_pc,
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_valid,
  output logic            cpu_ce,
  output logic            running,
  output logic            step_done,
  output logic [1:0]      halted_by
);

  step_state_t         state_r;
  step_state_t         state_nxt_s;
  logic [1:0]          halted_by_r;
  logic [1:0]          halted_by_nxt_s;
  logic                step_done_r;
  logic                run_press_s;
  logic                step_press_s;
  logic                halt_press_s;
  logic                slow_s1_r;
  logic                slow_s2_r;
  logic                slow_en_r;
  logic [SLOW_DIV-1:0] slow_cnt_r;
  logic                tick_s;
  logic                bp_hit_s;
  logic                cpu_ce_s;
  logic                enter_run_s;

  rv523_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst(rst), .btn(btn_run), .press(run_press_s)
  );
  rv523_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst(rst), .btn(btn_step), .press(step_press_s)
  );
  rv523_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_halt (
    .clk(clk), .rst(rst), .btn(btn_halt), .press(halt_press_s)
  );

  // slow_en_r lags the synchronised switch by one cycle so the counter is already cleared when it applies
  assign tick_s = slow_en_r ? (slow_cnt_r == {SLOW_DIV{1'b1}}) : 1'b1;

`ifdef RV523_BREAKPOINT_EN
  assign bp_hit_s = bp_valid && (cpu_pc == bp_addr) && tick_s;
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{cpu_pc, bp_addr, bp_valid};
  assign bp_hit_s    = 1'b0;
`endif

  // Next state, halt cause and clock-enable gating from registered state
  always_comb begin
    state_nxt_s     = state_r;
    halted_by_nxt_s = halted_by_r;
    cpu_ce_s        = 1'b0;
    case (state_r)
      ST_HALT: begin
        if (step_press_s) begin
          state_nxt_s     = ST_STEP;
          halted_by_nxt_s = HC_NONE;
        end else if (run_press_s) begin
          state_nxt_s     = ST_RUN;
          halted_by_nxt_s = HC_NONE;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      ST_STEP: begin
        cpu_ce_s    = 1'b1;
        state_nxt_s = ST_HALT;
      end
      ST_RUN: begin
        cpu_ce_s = tick_s & ~halt_req & ~bp_hit_s;
        if (halt_req) begin
          state_nxt_s     = ST_HALT;
          halted_by_nxt_s = HC_REQ;
        end else if (bp_hit_s) begin
          state_nxt_s     = ST_HALT;
          halted_by_nxt_s = HC_BP;
        end else if (halt_press_s) begin
          state_nxt_s     = ST_HALT;
          halted_by_nxt_s = HC_NONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s     = ST_HALT;
        halted_by_nxt_s = HC_NONE;
      end
    endcase
  end

  assign enter_run_s = (state_r != ST_RUN) && (state_nxt_s == ST_RUN);

  // Controller state, halt cause and step-completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_HALT;
      halted_by_r <= HC_NONE;
      step_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      halted_by_r <= halted_by_nxt_s;
      step_done_r <= (state_r == ST_STEP);
    end
  end

  // Slow-run switch synchroniser and tick divider
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_s1_r  <= 1'b0;
      slow_s2_r  <= 1'b0;
      slow_en_r  <= 1'b0;
      slow_cnt_r <= {SLOW_DIV{1'b0}};
    end else begin
      slow_s1_r <= sw_slow;
      slow_s2_r <= slow_s1_r;
      slow_en_r <= slow_s2_r;
      if (enter_run_s || (slow_s2_r && !slow_en_r)) begin
        slow_cnt_r <= {SLOW_DIV{1'b0}};
      end else if ((state_r == ST_RUN) && slow_en_r) begin
        slow_cnt_r <= slow_cnt_r + {{(SLOW_DIV-1){1'b0}}, 1'b1};
      end else begin
        slow_cnt_r <= slow_cnt_r;
      end
    end
  end

  assign cpu_ce    = cpu_ce_s;
  assign running   = (state_r == ST_RUN);
  assign step_done = step_done_r;
  assign halted_by = halted_by_r;

endmodule

// File: tb/tb_rv523_step_ctrl.sv
// Self-checking bench for rv523_step_ctrl: directed vector table, corner sequences and random ops vs a mode model.
module tb_rv523_step_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_run;
  logic        btn_step;
  logic        btn_halt;
  logic        sw_slow;
  logic        halt_req;
  logic [31:0] cpu_pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        cpu_ce;
  logic        running;
  logic        step_done;
  logic [1:0]  halted_by;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_idx  = 0;
  int ce_total = 0;
  int sd_total = 0;
  int last_ce  = -1;
  int last_sd  = -1;

  // Operations: 0 press step, 1 press run, 2 press halt, 3 halt_req pulse, 4 observe 20 cycles
  typedef struct {
    int op;
    int exp_run;
    int exp_hb;
    int exp_ce;   // -1 = not checked
    int exp_sd;
  } vec_t;

  vec_t vecs[11];

  rv523_step_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .SLOW_DIV(3),
    .PC_W(32)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .btn_halt(btn_halt),
    .sw_slow(sw_slow), .halt_req(halt_req), .cpu_pc(cpu_pc), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .cpu_ce(cpu_ce), .running(running), .step_done(step_done),
    .halted_by(halted_by)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple CPU stand-in: PC advances by 4 on every enabled cycle
  always @(posedge clk) begin
    if (rst) cpu_pc <= 32'd0;
    else if (cpu_ce) cpu_pc <= cpu_pc + 32'd4;
  end

  always @(negedge clk) begin
    cyc_idx <= cyc_idx + 1;
    if (cpu_ce === 1'b1) begin
      ce_total <= ce_total + 1;
      last_ce  <= cyc_idx;
    end
    if (step_done === 1'b1) begin
      sd_total <= sd_total + 1;
      last_sd  <= cyc_idx;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_step = 1'b1;
      1: btn_run  = 1'b1;
      2: btn_halt = 1'b1;
      default: ;
    endcase
    repeat (12) cyc();
    btn_step = 1'b0;
    btn_run  = 1'b0;
    btn_halt = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic do_op(input int op, output int ce, output int sd);
    int ce0;
    int sd0;
    ce0 = ce_total;
    sd0 = sd_total;
    case (op)
      0, 1, 2: press(op);
      3: begin
        halt_req = 1'b1;
        @(negedge clk);
        check("halt_req_ce_same_cycle", cpu_ce, 0);
        @(posedge clk);
        #1;
        halt_req = 1'b0;
        repeat (2) cyc();
      end
      4: repeat (20) cyc();
      default: ;
    endcase
    ce = ce_total - ce0;
    sd = sd_total - sd0;
  endtask

  task automatic apply_and_check(input string tag, input vec_t v);
    int ce;
    int sd;
    do_op(v.op, ce, sd);
    check({tag, "_running"}, running, v.exp_run);
    check({tag, "_halted_by"}, halted_by, v.exp_hb);
    if (v.exp_ce >= 0) check({tag, "_ce_count"}, ce, v.exp_ce);
    if (v.exp_sd >= 0) check({tag, "_step_done"}, sd, v.exp_sd);
  endtask

  initial begin
    int ce0;
    int sd0;
    int found;
    int np;
    int first;
    int prev;
    int gaps_ok;
    int m_run;
    int m_hb;
    vec_t v;

    vecs[0]  = '{0, 0, 0, 1, 1};
    vecs[1]  = '{1, 1, 0, -1, 0};
    vecs[2]  = '{4, 1, 0, 20, 0};
    vecs[3]  = '{0, 1, 0, 24, 0};
    vecs[4]  = '{1, 1, 0, 24, 0};
    vecs[5]  = '{3, 0, 1, 0, 0};
    vecs[6]  = '{4, 0, 1, 0, 0};
    vecs[7]  = '{2, 0, 1, 0, 0};
    vecs[8]  = '{1, 1, 0, -1, 0};
    vecs[9]  = '{2, 0, 0, -1, 0};
    vecs[10] = '{0, 0, 0, 1, 1};

    rst = 1'b1; btn_run = 1'b1; btn_step = 1'b1; btn_halt = 1'b1;
    sw_slow = 1'b0; halt_req = 1'b0; bp_addr = 32'h0000_0010; bp_valid = 1'b0;

    // Reset with all buttons held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cpu_ce", cpu_ce, 0);
    check("reset_running", running, 0);
    check("reset_halted_by", halted_by, 0);
    check("reset_step_done", step_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_halt = 1'b0;
    ce0 = ce_total;
    repeat (15) cyc();
    check("post_reset_no_ce", ce_total - ce0, 0);
    check("post_reset_running", running, 0);

    // Bouncing step button
    ce0 = ce_total;
    sd0 = sd_total;
    for (int i = 0; i < 5; i++) begin
      btn_step = (i % 2 == 0);
      repeat (2) cyc();
    end
    btn_step = 1'b1;
    repeat (12) cyc();
    btn_step = 1'b0;
    repeat (12) cyc();
    check("bounce_ce_count", ce_total - ce0, 1);
    check("bounce_step_done", sd_total - sd0, 1);
    check("bounce_step_done_follows_ce", last_sd, last_ce + 1);

    // Directed vector table
    for (int i = 0; i < 11; i++) apply_and_check($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous step+run in HALT
    ce0 = ce_total;
    sd0 = sd_total;
    btn_run = 1'b1;
    press(0);
    check("prio_ce_count", ce_total - ce0, 1);
    check("prio_step_done", sd_total - sd0, 1);
    check("prio_running", running, 0);

    // Slow run: one enable every 8 cycles from RUN entry
    sw_slow = 1'b1;
    repeat (5) cyc();
    btn_run = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (running) begin
        found = 1;
        break;
      end
    end
    check("slow_enter_run", found, 1);
    np = 0; first = -1; prev = -1; gaps_ok = 1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (cpu_ce) begin
        if (first < 0) first = i;
        if (prev >= 0 && i - prev != 8) gaps_ok = 0;
        prev = i;
        np++;
      end
    end
    check("slow_pulse_count", np, 4);
    check("slow_first_pulse", first, 7);
    check("slow_period_8", gaps_ok, 1);
    @(posedge clk);
    #1;
    btn_run = 1'b0;
    press(2);
    sw_slow = 1'b0;
    check("slow_halted", running, 0);
    repeat (5) cyc();

    // Random operations against a run/halt mode model
    m_run = 0;
    m_hb  = halted_by;
    check("rand_start_hb", m_hb, 0);
    for (int i = 0; i < 30; i++) begin
      v.op = $urandom_range(0, 4);
      v.exp_sd = 0;
      v.exp_ce = 0;
      case (v.op)
        0: if (m_run == 0) begin v.exp_ce = 1; v.exp_sd = 1; m_hb = 0; end else v.exp_ce = 24;
        1: if (m_run == 0) begin m_run = 1; m_hb = 0; v.exp_ce = -1; end else v.exp_ce = 24;
        2: if (m_run == 1) begin m_run = 0; m_hb = 0; v.exp_ce = -1; end else v.exp_ce = 0;
        3: if (m_run == 1) begin m_run = 0; m_hb = 1; end
        default: v.exp_ce = (m_run == 1) ? 20 : 0;
      endcase
      v.exp_run = m_run;
      v.exp_hb  = m_hb;
      apply_and_check($sformatf("rand%0d_op%0d", i, v.op), v);
    end

    // Reset while running stops cpu_ce after the reset edge
    press(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_ce", cpu_ce, 0);
    check("midrun_reset_running", running, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ce0 = ce_total;
    repeat (5) cyc();
    check("midrun_reset_no_ce", ce_total - ce0, 0);

    // Breakpoint at PC 0x10
    bp_valid = 1'b1;
    ce0 = ce_total;
    press(1);
`ifdef RV523_BREAKPOINT_EN
    check("bp_running", running, 0);
    check("bp_halted_by", halted_by, 2);
    check("bp_pc", cpu_pc, 32'h10);
    check("bp_ce_count", ce_total - ce0, 4);
    ce0 = ce_total;
    press(0);
    check("bp_stepoff_ce", ce_total - ce0, 1);
    check("bp_stepoff_pc", cpu_pc, 32'h14);
    check("bp_stepoff_hb", halted_by, 0);
`else
    check("nobp_running", running, 1);
    check("nobp_halted_by", halted_by, 0);
    check("nobp_pc_past_bp", (cpu_pc > 32'h10), 1);
    check("nobp_pc_tracks_ce", cpu_pc, 4 * (ce_total - ce0));
    press(2);
    check("nobp_halt_press", running, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
